// File: rtl/pq_bfly_pkg.sv
// Shared constants, FSM state type and index helpers for the PQ butterfly sequencer.
package pq_bfly_pkg;

    localparam int unsigned PQ_Q        = 3329;
    localparam int unsigned PQ_BARRETT  = 5039;
    localparam int unsigned PQ_NUM_REGS = 32;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } bfly_state_e;

    // Low index of pair p at log2 stride k: insert a zero bit at position k of p.
    function automatic logic [4:0] pair_lo_idx(input logic [3:0] p, input logic [2:0] k);
        logic [4:0] mask;
        logic [4:0] lo;
        logic [4:0] hi;
        mask = (5'd1 << k) - 5'd1;
        lo   = {1'b0, p} & mask;
        hi   = ({1'b0, p} >> k) << (k + 3'd1);
        return hi | lo;
    endfunction

    // Single conditional subtraction; valid for inputs below 2q.
    function automatic logic [11:0] mod_q_sub(input logic [12:0] v);
        logic [12:0] d;
        d = v - 13'(PQ_Q);
        if (v >= 13'(PQ_Q)) begin
            return d[11:0];
        end
        return v[11:0];
    endfunction

endpackage

// File: rtl/pq_mod_reduce.sv
// Combinational Barrett reduction of a 24-bit product to a 12-bit residue mod q.
module pq_mod_reduce
    import pq_bfly_pkg::*;
(
    input  logic [23:0] x_i,
    output logic [11:0] r_o
);

    logic [36:0] scaled;
    logic [12:0] t;
    logic [23:0] tq;
    logic [23:0] r;
    logic [23:0] r_sub;

    always_comb begin
        scaled = 37'(x_i) * 37'(PQ_BARRETT);
        t      = scaled[36:24];
        tq     = 24'(t) * 24'(PQ_Q);
        // The quotient estimate is at most one short, so r < 2q.
        r      = x_i - tq;
        r_sub  = r - 24'(PQ_Q);
        r_o    = (r >= 24'(PQ_Q)) ? r_sub[11:0] : r[11:0];
    end

endmodule

// File: rtl/pq_rf_butterfly_seq.sv
// Runs one NTT butterfly pass over the 32 PQ register-file words and writes results back.
// Define PQ_BFLY_GS_EN to build the Gentleman-Sande datapath (op_i = 1); otherwise CT only.
module pq_rf_butterfly_seq
    import pq_bfly_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned COEF_WIDTH = 12
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_i,
    input  logic                                   op_i,
    input  logic [2:0]                             stride_i,
    input  logic [COEF_WIDTH-1:0]                  zeta_i,
    input  logic [PQ_NUM_REGS-1:0][DATA_WIDTH-1:0] rdata_pq_i,
    output logic [PQ_NUM_REGS-1:0][DATA_WIDTH-1:0] wdata_pq_o,
    output logic [PQ_NUM_REGS-1:0]                 we_pq_o,
    output logic                                   busy_o,
    output logic                                   done_o
);

    bfly_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  k_q;
    logic [11:0] zeta_q;
    logic        latch_cfg;
    logic        issue;

    // Control FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_cfg = 1'b0;
        issue     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StIssue;
                    cnt_d     = 4'd0;
                    latch_cfg = 1'b1;
                end
            end
            StIssue: begin
                issue = 1'b1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = StDrain;
                    cnt_d   = 4'd0;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StDone;
                    cnt_d   = 4'd0;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (start_i) begin
                    state_d   = StIssue;
                    cnt_d     = 4'd0;
                    latch_cfg = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            k_q     <= 3'd0;
            zeta_q  <= 12'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_cfg) begin
                k_q    <= (stride_i > 3'd4) ? 3'd4 : stride_i;
                zeta_q <= 12'(zeta_i);
            end
        end
    end

    assign busy_o = (state_q == StIssue) || (state_q == StDrain);
    assign done_o = (state_q == StDone);

    // S0: fetch the pair and pre-reduce both operands
    logic [4:0]  s0_lo, s0_hi;
    logic [11:0] s0_a, s0_b, s0_x, s0_y;

    always_comb begin
        s0_lo = pair_lo_idx(cnt_q, k_q);
        s0_hi = s0_lo + (5'd1 << k_q);
        s0_a  = mod_q_sub({1'b0, 12'(rdata_pq_i[s0_lo][COEF_WIDTH-1:0])});
        s0_b  = mod_q_sub({1'b0, 12'(rdata_pq_i[s0_hi][COEF_WIDTH-1:0])});
    end

`ifdef PQ_BFLY_GS_EN
    logic op_q;
    logic s1_gs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= 1'b0;
        end else if (latch_cfg) begin
            op_q <= op_i;
        end
    end

    // GS forms sum and difference up front; x carries a+b, y carries a-b.
    always_comb begin
        s0_x = s0_a;
        s0_y = s0_b;
        if (op_q) begin
            s0_x = mod_q_sub(13'(s0_a) + 13'(s0_b));
            s0_y = mod_q_sub(13'(s0_a) + 13'(PQ_Q) - 13'(s0_b));
        end
    end
`else
    logic unused_op;
    assign unused_op = op_i;
    assign s0_x      = s0_a;
    assign s0_y      = s0_b;
`endif

    logic unused_rdata_hi;
    always_comb begin
        unused_rdata_hi = 1'b0;
        for (int i = 0; i < int'(PQ_NUM_REGS); i++) begin
            unused_rdata_hi = unused_rdata_hi ^ (^rdata_pq_i[i][DATA_WIDTH-1:COEF_WIDTH]);
        end
    end

    // S0/S1 pipeline register
    logic        s1_vld_q;
    logic [4:0]  s1_lo_q, s1_hi_q;
    logic [11:0] s1_x_q, s1_y_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_lo_q  <= 5'd0;
            s1_hi_q  <= 5'd0;
            s1_x_q   <= 12'd0;
            s1_y_q   <= 12'd0;
`ifdef PQ_BFLY_GS_EN
            s1_gs_q  <= 1'b0;
`endif
        end else begin
            s1_vld_q <= issue;
            s1_lo_q  <= s0_lo;
            s1_hi_q  <= s0_hi;
            s1_x_q   <= s0_x;
            s1_y_q   <= s0_y;
`ifdef PQ_BFLY_GS_EN
            s1_gs_q  <= op_q;
`endif
        end
    end

    // S1 multiply and S2 reduce/combine feed the registered write port.
    logic [23:0] s1_prod;
    logic [11:0] s2_r, s2_ct_a, s2_ct_b, s2_a, s2_b;

    assign s1_prod = 24'(zeta_q) * 24'(s1_y_q);

    pq_mod_reduce u_reduce (
        .x_i (s1_prod),
        .r_o (s2_r)
    );

    assign s2_ct_a = mod_q_sub(13'(s1_x_q) + 13'(s2_r));
    assign s2_ct_b = mod_q_sub(13'(s1_x_q) + 13'(PQ_Q) - 13'(s2_r));

`ifdef PQ_BFLY_GS_EN
    assign s2_a = s1_gs_q ? s1_x_q : s2_ct_a;
    assign s2_b = s1_gs_q ? s2_r   : s2_ct_b;
`else
    assign s2_a = s2_ct_a;
    assign s2_b = s2_ct_b;
`endif

    logic [PQ_NUM_REGS-1:0][DATA_WIDTH-1:0] wdata_d, wdata_q;
    logic [PQ_NUM_REGS-1:0]                 we_d, we_q;

    always_comb begin
        we_d    = '0;
        wdata_d = '0;
        if (s1_vld_q) begin
            we_d[s1_lo_q]    = 1'b1;
            we_d[s1_hi_q]    = 1'b1;
            wdata_d[s1_lo_q] = DATA_WIDTH'(s2_a);
            wdata_d[s1_hi_q] = DATA_WIDTH'(s2_b);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign we_pq_o    = we_q;
    assign wdata_pq_o = wdata_q;

endmodule

// File: tb/tb_pq_rf_butterfly_seq.sv
// Scoreboard bench for pq_rf_butterfly_seq: expected writes queued at start, checked on output.
module tb_pq_rf_butterfly_seq;

    localparam int Q = 3329;
`ifdef PQ_BFLY_GS_EN
    localparam bit GS_BUILT = 1'b1;
`else
    localparam bit GS_BUILT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic              op_i = 1'b0;
    logic [2:0]        stride_i = 3'd0;
    logic [11:0]       zeta_i = 12'd0;
    logic [31:0][31:0] rdata_pq_i = '0;
    logic [31:0][31:0] wdata_pq_o;
    logic [31:0]       we_pq_o;
    logic              busy_o;
    logic              done_o;

    pq_rf_butterfly_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .stride_i   (stride_i),
        .zeta_i     (zeta_i),
        .rdata_pq_i (rdata_pq_i),
        .wdata_pq_o (wdata_pq_o),
        .we_pq_o    (we_pq_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lo;
        int hi;
        int va;
        int vb;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mon_we;
    int          errors = 0;
    int          checks = 0;
    int          write_cnt = 0;
    int          done_cnt = 0;

    // Output monitor: every write cycle must match the next queued pair.
    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (we_pq_o != 32'd0) begin
            write_cnt += $countones(we_pq_o);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: we=%h but no write expected", we_pq_o);
            end else begin
                mon_e  = sb.pop_front();
                mon_we = (32'd1 << mon_e.lo) | (32'd1 << mon_e.hi);
                checks++;
                if (we_pq_o !== mon_we) begin
                    errors++;
                    $display("FAIL we_pattern: got %h want %h", we_pq_o, mon_we);
                end
                checks++;
                if (wdata_pq_o[mon_e.lo] !== 32'(mon_e.va)) begin
                    errors++;
                    $display("FAIL wdata_lo[%0d]: got %0d want %0d", mon_e.lo,
                             wdata_pq_o[mon_e.lo], mon_e.va);
                end
                checks++;
                if (wdata_pq_o[mon_e.hi] !== 32'(mon_e.vb)) begin
                    errors++;
                    $display("FAIL wdata_hi[%0d]: got %0d want %0d", mon_e.hi,
                             wdata_pq_o[mon_e.hi], mon_e.vb);
                end
            end
        end
    end

    // Queue the expected writes for a pass, then pulse start; returns in cycle 1.
    task automatic start_pass(input bit op, input int stride, input int zeta);
        int k, s, a, b, r, va, vb;
        exp_t e;
        k = (stride > 4) ? 4 : stride;
        s = 1 << k;
        for (int j = 0; j < 32; j++) begin
            if (((j >> k) & 1) == 0) begin
                a = int'(rdata_pq_i[j][11:0]) % Q;
                b = int'(rdata_pq_i[j + s][11:0]) % Q;
                if (op && GS_BUILT) begin
                    va = (a + b) % Q;
                    vb = (zeta * ((a - b + Q) % Q)) % Q;
                end else begin
                    r  = (zeta * b) % Q;
                    va = (a + r) % Q;
                    vb = (a - r + Q) % Q;
                end
                e.lo = j; e.hi = j + s; e.va = va; e.vb = vb;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        start_i  = 1'b1;
        op_i     = op;
        stride_i = 3'(stride);
        zeta_i   = 12'(zeta);
        @(negedge clk);
        start_i  = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) rdata_pq_i[i] = $urandom;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            #1;
            checks++;
            if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
            checks++;
            if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
            checks++;
            if (we_pq_o !== 32'd0) begin errors++; $display("FAIL reset_we: got %h want 0", we_pq_o); end
            checks++;
            if (wdata_pq_o !== '0) begin errors++; $display("FAIL reset_wdata: nonzero, want 0"); end
        end
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ct_k0();
        int w0, d0;
        for (int i = 0; i < 32; i++) rdata_pq_i[i] = 32'(i);
        w0 = write_cnt; d0 = done_cnt;
        start_pass(1'b0, 0, 1);
        for (int n = 1; n <= 20; n++) begin
            #1;
            checks++;
            if (busy_o !== (n <= 18)) begin errors++; $display("FAIL ct0_busy c%0d: got %b", n, busy_o); end
            checks++;
            if (done_o !== (n == 19)) begin errors++; $display("FAIL ct0_done c%0d: got %b", n, done_o); end
            if (n == 2) begin
                checks++;
                if (we_pq_o !== 32'd0) begin errors++; $display("FAIL ct0_early_we: got %h want 0", we_pq_o); end
            end
            if (n == 3) begin
                checks++;
                if (we_pq_o !== 32'h3) begin errors++; $display("FAIL ct0_first_we: got %h want 3", we_pq_o); end
                checks++;
                if (wdata_pq_o[0] !== 32'd1 || wdata_pq_o[1] !== 32'd3328) begin
                    errors++;
                    $display("FAIL ct0_first_data: got %0d,%0d want 1,3328", wdata_pq_o[0], wdata_pq_o[1]);
                end
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (write_cnt - w0 != 32) begin errors++; $display("FAIL ct0_writes: got %0d want 32", write_cnt - w0); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL ct0_dones: got %0d want 1", done_cnt - d0); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL ct0_pending: got %0d want 0", sb.size()); end
    endtask

    task automatic test_ct_k4();
        logic [31:0] exp_we;
        for (int i = 0; i < 32; i++) rdata_pq_i[i] = 32'd3328;
        start_pass(1'b0, 4, 17);
        for (int n = 1; n <= 20; n++) begin
            #1;
            if (n >= 3 && n <= 18) begin
                exp_we = (32'd1 << (n - 3)) | (32'd1 << (n + 13));
                checks++;
                if (we_pq_o !== exp_we) begin errors++; $display("FAIL ct4_we c%0d: got %h want %h", n, we_pq_o, exp_we); end
                checks++;
                if (wdata_pq_o[n - 3] !== 32'd3311 || wdata_pq_o[n + 13] !== 32'd16) begin
                    errors++;
                    $display("FAIL ct4_data c%0d: got %0d,%0d want 3311,16", n,
                             wdata_pq_o[n - 3], wdata_pq_o[n + 13]);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL ct4_pending: got %0d want 0", sb.size()); end
    endtask

    task automatic test_stride_clamp();
        fill_random();
        rdata_pq_i[3] = 32'hFFFF_FFFF;
        start_pass(1'b0, 7, int'($urandom_range(0, 4095)));
        repeat (21) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL clamp_pending: got %0d want 0", sb.size()); end
    endtask

    task automatic test_gs();
        fill_random();
        rdata_pq_i[0] = 32'd10;
        rdata_pq_i[2] = 32'd4;
        rdata_pq_i[1] = 32'hABCD_0FFF;
        rdata_pq_i[3] = 32'd5;
        start_pass(1'b1, 1, 2);
        for (int n = 1; n <= 20; n++) begin
            #1;
`ifdef PQ_BFLY_GS_EN
            if (n == 3) begin
                checks++;
                if (wdata_pq_o[0] !== 32'd14 || wdata_pq_o[2] !== 32'd12) begin
                    errors++;
                    $display("FAIL gs_pair0: got %0d,%0d want 14,12", wdata_pq_o[0], wdata_pq_o[2]);
                end
            end
`endif
            if (n == 4) begin
                checks++;
                if (we_pq_o !== 32'ha) begin errors++; $display("FAIL gs_pair1_we: got %h want a", we_pq_o); end
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL gs_pending: got %0d want 0", sb.size()); end
    endtask

    task automatic test_start_while_busy();
        int w0, d0;
        fill_random();
        w0 = write_cnt; d0 = done_cnt;
        start_pass(1'b0, 2, int'($urandom_range(0, 4095)));
        for (int n = 1; n <= 22; n++) begin
            #1;
            if (n == 5) begin
                start_i = 1'b1; op_i = 1'b1; stride_i = 3'd0; zeta_i = 12'd99;
            end
            if (n == 6) start_i = 1'b0;
            if (n >= 19) begin
                checks++;
                if (busy_o !== 1'b0) begin errors++; $display("FAIL busy_restart c%0d: got %b want 0", n, busy_o); end
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (write_cnt - w0 != 32) begin errors++; $display("FAIL busy_writes: got %0d want 32", write_cnt - w0); end
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_dones: got %0d want 1", done_cnt - d0); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL busy_pending: got %0d want 0", sb.size()); end
    endtask

    task automatic test_reset_mid_pass();
        int w0, d0;
        fill_random();
        w0 = write_cnt; d0 = done_cnt;
        start_pass(1'b0, 3, int'($urandom_range(0, 4095)));
        for (int n = 1; n < 10; n++) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (we_pq_o !== 32'd0) begin errors++; $display("FAIL midrst_we: got %h want 0", we_pq_o); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
        checks++;
        if (write_cnt - w0 != 16) begin errors++; $display("FAIL midrst_writes: got %0d want 16", write_cnt - w0); end
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        checks++;
        if (write_cnt - w0 != 16) begin errors++; $display("FAIL midrst_late_writes: got %0d want 16", write_cnt - w0); end
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL midrst_done: got %0d want 0", done_cnt - d0); end

        fill_random();
        d0 = done_cnt;
        start_pass(1'b0, 1, int'($urandom_range(0, 4095)));
        repeat (21) @(negedge clk);
        #1;
        checks++;
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL postrst_done: got %0d want 1", done_cnt - d0); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL postrst_pending: got %0d want 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_ct_k0();
        test_ct_k4();
        test_stride_clamp();
        test_gs();
        test_start_while_busy();
        test_reset_mid_pass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
